// File: rtl/cmp_serial_mag.sv
// Serial magnitude comparator. One 4-bit cascade slice is reused once per clock,
// LSB nibble first, and the relation is returned over a valid/ready handshake.
module cmp_slice4 (
    input  logic [3:0] a_i,
    input  logic [3:0] b_i,
    input  logic       gt_i,
    input  logic       eq_i,
    input  logic       lt_i,
    output logic       gt_o,
    output logic       eq_o,
    output logic       lt_o
);
    // The cascade inputs carry the verdict of the less significant nibbles;
    // this nibble overrides that verdict unless the two nibbles are equal.
    assign gt_o = (a_i > b_i) | ((a_i == b_i) & gt_i);
    assign lt_o = (a_i < b_i) | ((a_i == b_i) & lt_i);
    assign eq_o = (a_i == b_i) & eq_i;
endmodule

module cmp_serial_mag #(
    parameter int WIDTH  = 16,
    parameter int SIGNED = 0
) (
    input  logic             CLK,
    input  logic             RST_N,
    input  logic             START_VALID,
    output logic             START_READY,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic [2:0]       MODE,
    output logic             RES_VALID,
    input  logic             RES_READY,
    output logic             Y,
    output logic             LT,
    output logic             EQ,
    output logic             GT
);
    localparam int N  = (WIDTH + 3) / 4;
    localparam int W4 = 4 * N;
    localparam int CW = (N > 1) ? $clog2(N) : 1;
    localparam logic [CW-1:0] LAST = CW'(N - 1);
    // Flipping the MSB of both operands maps two's complement onto unsigned order.
    localparam logic [W4-1:0] MSB_FLIP = (SIGNED != 0) ? (W4'(1) << (W4 - 1)) : '0;

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t          state_q, state_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic            g_q, g_d, e_q, e_d, l_q, l_d;
    logic [W4-1:0]   a_q, a_d, b_q, b_d;
    logic [2:0]      mode_q, mode_d;
    logic            y_q, y_d, lt_q, lt_d, eq_q, eq_d, gt_q, gt_d;
    logic [W4-1:0]   a_ext, b_ext;
    logic            s_gt, s_eq, s_lt;

    for (genvar gi = 0; gi < W4; gi++) begin : g_ext
        if (gi < WIDTH) begin : g_in
            assign a_ext[gi] = A[gi];
            assign b_ext[gi] = B[gi];
        end else begin : g_pad
            assign a_ext[gi] = (SIGNED != 0) ? A[WIDTH-1] : 1'b0;
            assign b_ext[gi] = (SIGNED != 0) ? B[WIDTH-1] : 1'b0;
        end
    end

    // The operand registers shift right by a nibble per RUN cycle, so the
    // slice always looks at the low nibble.
    cmp_slice4 u_slice (
        .a_i  (a_q[3:0]),
        .b_i  (b_q[3:0]),
        .gt_i (g_q),
        .eq_i (e_q),
        .lt_i (l_q),
        .gt_o (s_gt),
        .eq_o (s_eq),
        .lt_o (s_lt)
    );

    function automatic logic sel_rel(input logic [2:0] m, input logic lt, input logic eq,
                                     input logic gt);
        case (m)
            3'd0:    sel_rel = lt;
            3'd1:    sel_rel = gt;
            3'd2:    sel_rel = ~gt;
            3'd3:    sel_rel = ~lt;
            3'd4:    sel_rel = eq;
            3'd5:    sel_rel = ~eq;
            default: sel_rel = 1'b0;
        endcase
    endfunction

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        g_d     = g_q;
        e_d     = e_q;
        l_d     = l_q;
        a_d     = a_q;
        b_d     = b_q;
        mode_d  = mode_q;
        y_d     = y_q;
        lt_d    = lt_q;
        eq_d    = eq_q;
        gt_d    = gt_q;
        case (state_q)
            IDLE: begin
                if (START_VALID) begin
                    a_d     = a_ext ^ MSB_FLIP;
                    b_d     = b_ext ^ MSB_FLIP;
                    mode_d  = MODE;
                    cnt_d   = '0;
                    g_d     = 1'b0;
                    e_d     = 1'b1;
                    l_d     = 1'b0;
                    state_d = RUN;
                end
            end
            RUN: begin
                a_d   = a_q >> 4;
                b_d   = b_q >> 4;
                g_d   = s_gt;
                e_d   = s_eq;
                l_d   = s_lt;
                cnt_d = cnt_q + CW'(1);
                if (cnt_q == LAST) begin
                    y_d     = sel_rel(mode_q, s_lt, s_eq, s_gt);
                    lt_d    = s_lt;
                    eq_d    = s_eq;
                    gt_d    = s_gt;
                    state_d = DONE;
                end
            end
            DONE: begin
                if (RES_READY) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            g_q     <= 1'b0;
            e_q     <= 1'b1;
            l_q     <= 1'b0;
            a_q     <= '0;
            b_q     <= '0;
            mode_q  <= '0;
            y_q     <= 1'b0;
            lt_q    <= 1'b0;
            eq_q    <= 1'b0;
            gt_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            g_q     <= g_d;
            e_q     <= e_d;
            l_q     <= l_d;
            a_q     <= a_d;
            b_q     <= b_d;
            mode_q  <= mode_d;
            y_q     <= y_d;
            lt_q    <= lt_d;
            eq_q    <= eq_d;
            gt_q    <= gt_d;
        end
    end

    assign START_READY = (state_q == IDLE);
    assign RES_VALID   = (state_q == DONE);
    assign Y  = y_q;
    assign LT = lt_q;
    assign EQ = eq_q;
    assign GT = gt_q;
endmodule

// File: tb/tb_cmp_serial_mag.sv
// Directed bench for cmp_serial_mag: three instances (16u, 12s, 10u) driven from a
// vector table, plus hand sequences for backpressure and asynchronous reset.
module tb_cmp_serial_mag;
    logic        CLK = 1'b0;
    logic        RST_N;
    logic [2:0]  sv;
    logic [15:0] A, B;
    logic [2:0]  MODE;
    logic        RR;
    logic [2:0]  sr, rv, y, lt, eq, gt;
    int          n_cmp = 0;
    int          n_err = 0;

    always #5 CLK = ~CLK;

    cmp_serial_mag #(.WIDTH(16), .SIGNED(0)) d16 (
        .CLK(CLK), .RST_N(RST_N), .START_VALID(sv[0]), .START_READY(sr[0]),
        .A(A), .B(B), .MODE(MODE), .RES_VALID(rv[0]), .RES_READY(RR),
        .Y(y[0]), .LT(lt[0]), .EQ(eq[0]), .GT(gt[0]));
    cmp_serial_mag #(.WIDTH(12), .SIGNED(1)) d12 (
        .CLK(CLK), .RST_N(RST_N), .START_VALID(sv[1]), .START_READY(sr[1]),
        .A(A[11:0]), .B(B[11:0]), .MODE(MODE), .RES_VALID(rv[1]), .RES_READY(RR),
        .Y(y[1]), .LT(lt[1]), .EQ(eq[1]), .GT(gt[1]));
    cmp_serial_mag #(.WIDTH(10), .SIGNED(0)) d10 (
        .CLK(CLK), .RST_N(RST_N), .START_VALID(sv[2]), .START_READY(sr[2]),
        .A(A[9:0]), .B(B[9:0]), .MODE(MODE), .RES_VALID(rv[2]), .RES_READY(RR),
        .Y(y[2]), .LT(lt[2]), .EQ(eq[2]), .GT(gt[2]));

    typedef struct {
        int          s;
        logic [15:0] a;
        logic [15:0] b;
        logic [2:0]  m;
        logic        ey, elt, eeq, egt;
        int          lat;
        bit          scr;
    } vec_t;

    vec_t vecs[13];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic start_op(input int s, input logic [15:0] a, input logic [15:0] b,
                            input logic [2:0] m);
        @(negedge CLK);
        A = a; B = b; MODE = m; sv[s] = 1'b1;
        chk("start_ready", 32'(sr[s]), 32'd1);
        @(posedge CLK);
        #1 sv[s] = 1'b0;
    endtask

    task automatic wait_res(input int s, input bit scr, output int lat);
        bit done = 0;
        lat = 0;
        while (!done && lat < 20) begin
            @(posedge CLK);
            #1 lat++;
            if (rv[s]) done = 1;
            else if (scr) begin
                A = 16'($urandom);
                B = 16'($urandom);
            end
        end
    endtask

    task automatic release_res(input int s);
        @(negedge CLK);
        RR = 1'b1;
        @(posedge CLK);
        #1 RR = 1'b0;
        chk("ready_after_done", 32'(sr[s]), 32'd1);
        chk("valid_after_done", 32'(rv[s]), 32'd0);
    endtask

    task automatic run_vec(input vec_t v);
        int lat;
        start_op(v.s, v.a, v.b, v.m);
        if (v.scr) begin
            A = 16'($urandom);
            B = 16'($urandom);
        end
        wait_res(v.s, v.scr, lat);
        chk("latency", 32'(lat), 32'(v.lat));
        chk("Y",  32'(y[v.s]),  32'(v.ey));
        chk("LT", 32'(lt[v.s]), 32'(v.elt));
        chk("EQ", 32'(eq[v.s]), 32'(v.eeq));
        chk("GT", 32'(gt[v.s]), 32'(v.egt));
        release_res(v.s);
    endtask

    initial begin
        int lat;
        bit seen;
        vecs[0]  = '{0, 16'h1234, 16'h1235, 3'd0, 1, 1, 0, 0, 4, 0};
        vecs[1]  = '{1, 16'h0800, 16'h07FF, 3'd1, 0, 1, 0, 0, 3, 0};
        vecs[2]  = '{0, 16'h0800, 16'h07FF, 3'd1, 1, 0, 0, 1, 4, 0};
        vecs[3]  = '{2, 16'h03FF, 16'h03FF, 3'd3, 1, 0, 1, 0, 3, 0};
        vecs[4]  = '{2, 16'h03FF, 16'h03FF, 3'd5, 0, 0, 1, 0, 3, 0};
        vecs[5]  = '{2, 16'h03FF, 16'h03FF, 3'd7, 0, 0, 1, 0, 3, 0};
        vecs[6]  = '{0, 16'hFFFF, 16'h0001, 3'd2, 0, 0, 0, 1, 4, 0};
        vecs[7]  = '{0, 16'hABCD, 16'hABCD, 3'd4, 1, 0, 1, 0, 4, 1};
        vecs[8]  = '{1, 16'h0FFF, 16'h0001, 3'd0, 1, 1, 0, 0, 3, 1};
        vecs[9]  = '{1, 16'h07FF, 16'h07FF, 3'd6, 0, 0, 1, 0, 3, 0};
        vecs[10] = '{0, 16'h00F0, 16'h0F00, 3'd3, 0, 1, 0, 0, 4, 0};
        vecs[11] = '{1, 16'h0123, 16'h0800, 3'd2, 0, 0, 0, 1, 3, 0};
        vecs[12] = '{2, 16'h0200, 16'h01FF, 3'd0, 0, 0, 0, 1, 3, 1};

        RST_N = 1'b0; sv = '0; RR = 1'b0; A = '0; B = '0; MODE = '0;
        #12;
        chk("rst_start_ready", 32'(sr), 32'h7);
        chk("rst_res_valid",   32'(rv), 32'h0);
        chk("rst_outputs",     32'({y, lt, eq, gt}), 32'h0);
        @(negedge CLK) RST_N = 1'b1;

        for (int i = 0; i < 13; i++) run_vec(vecs[i]);

        // Backpressure: result held while a new request is presented and dropped.
        start_op(0, 16'h5555, 16'h1111, 3'd1);
        wait_res(0, 0, lat);
        chk("bp_latency", 32'(lat), 32'd4);
        for (int c = 0; c < 5; c++) begin
            @(negedge CLK);
            if (c == 2) begin
                A = 16'h0000; B = 16'hFFFF; MODE = 3'd0; sv[0] = 1'b1;
            end else sv[0] = 1'b0;
            @(posedge CLK);
            #1;
            chk("bp_hold", 32'({rv[0], sr[0], y[0], lt[0], eq[0], gt[0]}), 32'b101001);
        end
        @(negedge CLK) sv[0] = 1'b0;
        release_res(0);
        seen = 0;
        for (int c = 0; c < 6; c++) begin
            @(posedge CLK);
            #1 if (rv[0] || !sr[0]) seen = 1;
        end
        chk("bp_pulse_ignored", 32'(seen), 32'd0);

        // Asynchronous reset in the middle of RUN.
        start_op(0, 16'h0001, 16'h0002, 3'd0);
        @(posedge CLK);
        @(posedge CLK);
        #3 RST_N = 1'b0;
        #1;
        chk("arst_ready", 32'(sr[0]), 32'd1);
        chk("arst_valid", 32'(rv[0]), 32'd0);
        chk("arst_outputs", 32'({y[0], lt[0], eq[0], gt[0]}), 32'h0);
        @(negedge CLK) RST_N = 1'b1;
        seen = 0;
        for (int c = 0; c < 8; c++) begin
            @(posedge CLK);
            #1 if (rv[0]) seen = 1;
        end
        chk("arst_no_spurious", 32'(seen), 32'd0);
        run_vec('{0, 16'h00FF, 16'h00FE, 3'd3, 1, 0, 0, 1, 4, 0});

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
